cop_spi_master: RTL and testbench
=================================

// Module: cop_spi_master
// PURPOSE
// Clocked SPI master driving the CoreLogic coprocessor port (cop_nss/cop_sck/cop_mosi/cop_miso).
// Sits in the coprocessor: turns a byte-stream request into a framed transfer to one encoded
// device select (logic, SD card, USB, FPGA, flash). Mode 0 (SCK idle low, sample on rise),
// LSB-first by default to match the CPLD shift registers.
// PARAMETERS
// CLK_DIV          4   clk cycles per SCK half-period (>=1)
// DEV_SELECT_WIDTH 3   width of encoded cop_nss select
// IDLE_SELECT      all-ones  cop_nss value when no device selected
// LEN_WIDTH        8   width of byte-count field
// PORTS
// clk        in   1         system clock
// nreset     in   1         async reset, active low
// start      in   1         request pulse; sampled only in IDLE
// dev_sel    in   DSW       device code, latched on accepted start
// num_bytes  in   LEN_WIDTH bytes to transfer, latched on accepted start
// tx_data    in   8         next byte to send
// tx_valid   in   1         tx_data valid
// tx_ready   out  1         1-cycle pulse: tx_data consumed (valid&ready = transfer)
// rx_data    out  8         last received byte
// rx_valid   out  1         1-cycle pulse: rx_data updated
// busy       out  1         high from accepted start until done
// done       out  1         1-cycle pulse at end of transfer
// cop_nss    out  DSW       encoded device select to CPLD
// cop_sck    out  1         SPI clock
// cop_mosi   out  1         SPI data out
// cop_miso   in   1         SPI data in
// BEHAVIOUR
// - Reset (async, nreset=0): cop_nss=IDLE_SELECT, cop_sck=0, cop_mosi=0, rx_data=0, all pulses/busy=0,
//   FSM=IDLE. Reset mid-transfer releases cop_nss immediately; no done/rx_valid issued.
// - States: IDLE, LOAD, SETUP, HIGH, LOW, HOLD, DONE.
// - IDLE: start=1 -> latch dev_sel,num_bytes; busy=1; num_bytes==0 -> DONE (no bus activity), else LOAD.
//   start while busy ignored; dev_sel/num_bytes changes after latch have no effect.
// - LOAD: tx_ready=1 while tx_valid=0 is waited on; on tx_valid: tx_ready pulses, shift reg<=tx_data,
//   cop_mosi<=bit0. First byte: cop_nss<=dev_sel same edge -> SETUP; later bytes -> LOW.
//   Stall (tx_valid low): SCK held low, cop_nss held asserted, indefinitely.
// - SETUP: CLK_DIV cycles, SCK low (nss-to-first-rise setup) -> HIGH.
// - HIGH: cop_sck=1 for CLK_DIV cycles; cop_miso sampled on the clk that raises SCK, shifted in at bit 7
//   (LSB-first assembly). After 8th high phase: rx_valid pulses with full byte on the falling edge.
// - LOW: cop_sck=0 for CLK_DIV cycles; next bit driven onto cop_mosi on the falling-edge clk.
//   Bits 1..7 -> HIGH; after bit 7 with bytes remaining -> LOAD; last byte -> HOLD.
// - HOLD: CLK_DIV cycles SCK low, nss asserted; then cop_nss<=IDLE_SELECT -> DONE.
// - DONE: done=1 one cycle, busy=0 on exit -> IDLE.
// - Byte counter: LEN_WIDTH bits, decrements after each byte; no wrap (0 ends transfer).
// - SCK period = 2*CLK_DIV clk; exactly 8*num_bytes rising edges per transfer; no glitch on cop_sck.
// CONFIGURATION
// COP_SPI_MSB_FIRST_EN defined: adds input msb_first (1 bit, latched on start); msb_first=1 sends
//   tx bit7 first and assembles rx MSB-first (for flash); msb_first=0 identical to default.
// Not defined: port absent, always LSB-first.
// TESTING
// 1 CLK_DIV=2, dev 0, 1 byte 0x0F, miso tied to mosi -> mosi at rises 1,1,1,1,0,0,0,0; rx 0x0F; 8 rises, 4 clk apart.
// 2 num_bytes=0 -> done pulses 2 cycles after start; cop_nss stays IDLE_SELECT, no SCK edge.
// 3 3 bytes 0x01,0x02,0x03, tx_valid withheld 10 clk before byte 2 -> SCK low & nss held in stall; 24 rises; rx 3 pulses.
// 4 start + dev_sel=4 pulsed mid-transfer -> ignored; cop_nss keeps original code; single done.
// 5 nreset low during bit 3 -> same-cycle cop_nss=IDLE_SELECT, sck=0, busy=0; no done/rx_valid.
// 6 COP_SPI_MSB_FIRST_EN, msb_first=1, 0x01 -> mosi 0,0,0,0,0,0,0,1; loopback rx 0x01.

Source files
------------

// File: rtl/cop_spi_master.sv
// cop_spi_master
//   Mode-0 SPI master for the CoreLogic coprocessor port. It takes a byte
//   stream through a valid/ready interface and frames it to one encoded
//   device select on cop_nss. SCK idles low and MISO is sampled on the
//   clk edge that raises SCK. Bit order is LSB-first by default.
//
//   Optional build macro: COP_SPI_MSB_FIRST_EN adds input msb_first, which
//   is latched on start. When msb_first=1, tx bit 7 is sent first and the
//   rx byte is assembled MSB-first.
//
// Parameters
//   CLK_DIV           clk cycles per SCK half-period (>=1)
//   DEV_SELECT_WIDTH  width of the encoded select
//   IDLE_SELECT       cop_nss value while no device is selected
//   LEN_WIDTH         width of the byte-count field
//
// Ports
//   clk, nreset           system clock, async active-low reset
//   start                 request pulse, sampled only while idle
//   dev_sel, num_bytes    transfer setup, latched on an accepted start
//   msb_first             (macro only) bit order, latched on start
//   tx_data/tx_valid      byte source; tx_ready high while a byte is awaited
//   rx_data/rx_valid      received byte, with a 1-cycle valid pulse
//   busy, done            transfer in progress; 1-cycle end pulse
//   cop_nss/cop_sck/cop_mosi/cop_miso  SPI pins
module cop_spi_master #(
  parameter int unsigned                 CLK_DIV          = 4,
  parameter int unsigned                 DEV_SELECT_WIDTH = 3,
  parameter logic [DEV_SELECT_WIDTH-1:0] IDLE_SELECT      = '1,
  parameter int unsigned                 LEN_WIDTH        = 8
) (
  input  logic                        clk,
  input  logic                        nreset,
  input  logic                        start,
  input  logic [DEV_SELECT_WIDTH-1:0] dev_sel,
  input  logic [LEN_WIDTH-1:0]        num_bytes,
`ifdef COP_SPI_MSB_FIRST_EN
  input  logic                        msb_first,
`endif
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  output logic                        busy,
  output logic                        done,
  output logic [DEV_SELECT_WIDTH-1:0] cop_nss,
  output logic                        cop_sck,
  output logic                        cop_mosi,
  input  logic                        cop_miso
);

  localparam int unsigned          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_DONE
  } state_t;

  state_t                        r_state;
  logic [DIV_W-1:0]              r_div;
  logic [LEN_WIDTH-1:0]          r_cnt;
  logic [DEV_SELECT_WIDTH-1:0]   r_dev;
  logic [DEV_SELECT_WIDTH-1:0]   r_nss;
  logic                          r_sck;
  logic                          r_mosi;
  logic [7:0]                    r_tx;
  logic [7:0]                    r_rx_sh;
  logic [7:0]                    r_rx_data;
  logic                          r_rx_valid;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_first;
  logic [3:0]                    r_nrise;   // SCK rises issued in current byte (0..8)

  logic                          w_msb;
  logic                          w_div_end;
  logic                          w_next_bit;
  logic [7:0]                    w_rx_shift;

`ifdef COP_SPI_MSB_FIRST_EN
  logic r_msb;
  assign w_msb = r_msb;
`else
  assign w_msb = 1'b0;
`endif

  assign w_div_end  = (r_div == DIV_LAST);
  // r_nrise is also the index of the next bit to drive after a fall
  assign w_next_bit = w_msb ? r_tx[~r_nrise[2:0]] : r_tx[r_nrise[2:0]];
  assign w_rx_shift = w_msb ? {r_rx_sh[6:0], cop_miso} : {cop_miso, r_rx_sh[7:1]};

  assign tx_ready = (r_state == S_LOAD);
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign cop_nss  = r_nss;
  assign cop_sck  = r_sck;
  assign cop_mosi = r_mosi;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_cnt      <= '0;
      r_dev      <= IDLE_SELECT;
      r_nss      <= IDLE_SELECT;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_tx       <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_first    <= 1'b0;
      r_nrise    <= '0;
`ifdef COP_SPI_MSB_FIRST_EN
      r_msb      <= 1'b0;
`endif
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dev   <= dev_sel;
            r_cnt   <= num_bytes;
            r_busy  <= 1'b1;
            r_first <= 1'b1;
`ifdef COP_SPI_MSB_FIRST_EN
            r_msb   <= msb_first;
`endif
            r_state <= (num_bytes == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (tx_valid) begin
            r_tx    <= tx_data;
            r_mosi  <= w_msb ? tx_data[7] : tx_data[0];
            r_nrise <= '0;
            r_div   <= '0;
            if (r_first) begin
              r_nss   <= r_dev;
              r_first <= 1'b0;
              r_state <= S_SETUP;
            end else begin
              r_state <= S_LOW;
            end
          end
        end
        S_SETUP: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sck   <= 1'b1;
            r_rx_sh <= w_rx_shift;
            r_nrise <= r_nrise + 4'd1;
            r_state <= S_HIGH;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HIGH: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_sck   <= 1'b0;
            r_state <= S_LOW;
            if (r_nrise == 4'd8) begin
              r_rx_data  <= r_rx_sh;
              r_rx_valid <= 1'b1;
              r_cnt      <= r_cnt - LEN_WIDTH'(1);
            end else begin
              r_mosi <= w_next_bit;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_LOW: begin
          if (w_div_end) begin
            r_div <= '0;
            if (r_nrise != 4'd8) begin
              r_sck   <= 1'b1;
              r_rx_sh <= w_rx_shift;
              r_nrise <= r_nrise + 4'd1;
              r_state <= S_HIGH;
            end else if (r_cnt != '0) begin
              r_state <= S_LOAD;
            end else begin
              r_state <= S_HOLD;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (w_div_end) begin
            r_div   <= '0;
            r_nss   <= IDLE_SELECT;
            r_state <= S_DONE;
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cop_spi_master.sv
// tb_cop_spi_master
//   Self-checking bench for cop_spi_master (CLK_DIV=2). Expected bit streams
//   and rx bytes come from a bit-order model applied to the bytes sent and to
//   the MISO values seen at each SCK rise.
module tb_cop_spi_master;
  localparam int unsigned      CLK_DIV = 2;
  localparam int unsigned      DSW     = 3;
  localparam logic [DSW-1:0]   IDLE    = '1;
  localparam int               PERIOD  = 10;

  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic           start = 1'b0;
  logic [DSW-1:0] dev_sel = '0;
  logic [7:0]     num_bytes = '0;
`ifdef COP_SPI_MSB_FIRST_EN
  logic           msb_first = 1'b0;
`endif
  logic [7:0]     tx_data = '0;
  logic           tx_valid = 1'b0;
  logic           tx_ready;
  logic [7:0]     rx_data;
  logic           rx_valid, busy, done;
  logic [DSW-1:0] cop_nss;
  logic           cop_sck, cop_mosi, cop_miso;
  logic           loopback = 1'b1;
  logic           miso_rand = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  bit cur_msb = 1'b0;

  logic [7:0]     txq[$];
  logic           rise_mosi[$];
  logic           rise_miso[$];
  time            rise_t[$];
  logic [DSW-1:0] rise_nss[$];
  logic [7:0]     rxq[$];
  int             done_cnt = 0;

  assign cop_miso = loopback ? cop_mosi : miso_rand;

  always #(PERIOD/2) clk = ~clk;

  cop_spi_master #(.CLK_DIV(CLK_DIV), .DEV_SELECT_WIDTH(DSW), .IDLE_SELECT(IDLE), .LEN_WIDTH(8)) dut (
    .clk(clk), .nreset(nreset), .start(start), .dev_sel(dev_sel), .num_bytes(num_bytes),
`ifdef COP_SPI_MSB_FIRST_EN
    .msb_first(msb_first),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
    .cop_nss(cop_nss), .cop_sck(cop_sck), .cop_mosi(cop_mosi), .cop_miso(cop_miso)
  );

  // Bus monitors: record what the slave would see at every SCK rise.
  always @(posedge cop_sck) begin
    rise_mosi.push_back(cop_mosi);
    rise_miso.push_back(cop_miso);
    rise_t.push_back($time);
    rise_nss.push_back(cop_nss);
  end
  always @(negedge cop_sck) miso_rand = 1'($urandom_range(0, 1));
  always @(negedge clk) begin
    if (rx_valid) rxq.push_back(rx_data);
    if (done) done_cnt++;
  end

  function automatic logic exp_bit(input logic [7:0] b, input int i);
    return cur_msb ? b[7-i] : b[i];
  endfunction

  function automatic logic [7:0] exp_rx(input int k);
    logic [7:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (8*k + i < rise_miso.size()) begin
        if (cur_msb) r[7-i] = rise_miso[8*k+i];
        else         r[i]   = rise_miso[8*k+i];
      end
    return r;
  endfunction

  task automatic clear_mon();
    rise_mosi.delete(); rise_miso.delete(); rise_t.delete(); rise_nss.delete();
    rxq.delete(); done_cnt = 0;
  endtask

  // Runs one transfer of txq; optional stall before byte stall_idx and an
  // extra start pulse (dev 4) at cycle mid_start.
  task automatic xfer(input logic [DSW-1:0] dev, input int stall_idx, input int stall_len,
                      input int mid_start, output int stalled, output int stall_bad);
    int idx = 0;
    int cyc = 0;
    bit fin = 1'b0;
    int n = txq.size();
    stalled = 0; stall_bad = 0;
    clear_mon();
    @(negedge clk);
    start = 1'b1; dev_sel = dev; num_bytes = 8'(n);
`ifdef COP_SPI_MSB_FIRST_EN
    msb_first = cur_msb;
`endif
    @(negedge clk);
    start = 1'b0; dev_sel = DSW'($urandom); num_bytes = 8'($urandom);
`ifdef COP_SPI_MSB_FIRST_EN
    msb_first = ~cur_msb;
`endif
    while (!fin && cyc < 4000) begin
      start = (cyc == mid_start);
      if (start) dev_sel = 3'd4;
      if (idx < n) begin
        if (idx == stall_idx && stalled < stall_len && tx_ready) begin
          tx_valid = 1'b0;
          stalled++;
          if (cop_sck !== 1'b0 || cop_nss !== dev) stall_bad++;
        end else begin
          tx_valid = 1'b1;
          tx_data  = txq[idx];
        end
        if (tx_valid && tx_ready) idx++;
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (done) fin = 1'b1;
    end
    start = 1'b0; tx_valid = 1'b0;
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL xfer_timeout: done=%b required 1 within 4000 cycles", done);
    end
    repeat (2*CLK_DIV + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++; if (cop_nss !== IDLE) begin miscompares++; $display("FAIL reset_nss: got %h required %h", cop_nss, IDLE); end
    vectors++; if (cop_sck !== 1'b0) begin miscompares++; $display("FAIL reset_sck: got %b required 0", cop_sck); end
    vectors++; if (cop_mosi !== 1'b0) begin miscompares++; $display("FAIL reset_mosi: got %b required 0", cop_mosi); end
    vectors++; if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
    vectors++; if ({busy, done, rx_valid} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b required 000", {busy, done, rx_valid}); end
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if (tx_ready !== 1'b0) begin miscompares++; $display("FAIL idle_tx_ready: got %b required 0", tx_ready); end
  endtask

  task automatic test_loopback_0f();
    int st, sb;
    loopback = 1'b1; cur_msb = 1'b0;
    txq = '{8'h0F};
    xfer(3'd0, -1, 0, -1, st, sb);
    vectors++; if (rise_mosi.size() != 8) begin miscompares++; $display("FAIL lb_rises: got %0d required 8", rise_mosi.size()); end
    for (int j = 0; j < rise_mosi.size() && j < 8; j++) begin
      vectors++;
      if (rise_mosi[j] !== exp_bit(8'h0F, j)) begin miscompares++; $display("FAIL lb_mosi[%0d]: got %b required %b", j, rise_mosi[j], exp_bit(8'h0F, j)); end
      if (j > 0) begin
        vectors++;
        if (rise_t[j] - rise_t[j-1] != 64'(2*CLK_DIV*PERIOD)) begin
          miscompares++; $display("FAIL lb_spacing[%0d]: got %0t required %0d", j, rise_t[j] - rise_t[j-1], 2*CLK_DIV*PERIOD);
        end
      end
      vectors++; if (rise_nss[j] !== 3'd0) begin miscompares++; $display("FAIL lb_nss[%0d]: got %h required 0", j, rise_nss[j]); end
    end
    vectors++; if (rxq.size() != 1) begin miscompares++; $display("FAIL lb_rx_count: got %0d required 1", rxq.size()); end
    else begin
      vectors++; if (rxq[0] !== 8'h0F) begin miscompares++; $display("FAIL lb_rx: got %h required 0f", rxq[0]); end
    end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL lb_done: got %0d required 1", done_cnt); end
    vectors++; if (cop_nss !== IDLE || busy !== 1'b0) begin miscompares++; $display("FAIL lb_end: nss=%h busy=%b required %h 0", cop_nss, busy, IDLE); end
  endtask

  task automatic test_zero_len();
    clear_mon();
    @(negedge clk); start = 1'b1; dev_sel = 3'd2; num_bytes = 8'd0;
    @(negedge clk); start = 1'b0;
    vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL zl_cycle1: busy,done=%b required 10", {busy, done}); end
    @(negedge clk);
    vectors++; if ({busy, done} !== 2'b01) begin miscompares++; $display("FAIL zl_cycle2: busy,done=%b required 01", {busy, done}); end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zl_cycle3: done=%b required 0", done); end
    repeat (4) @(negedge clk);
    vectors++; if (rise_t.size() != 0) begin miscompares++; $display("FAIL zl_sck: got %0d rises required 0", rise_t.size()); end
    vectors++; if (cop_nss !== IDLE) begin miscompares++; $display("FAIL zl_nss: got %h required %h", cop_nss, IDLE); end
  endtask

  task automatic test_stall();
    int st, sb;
    loopback = 1'b1; cur_msb = 1'b0;
    txq = '{8'h01, 8'h02, 8'h03};
    xfer(3'd1, 1, 10, -1, st, sb);
    vectors++; if (st != 10) begin miscompares++; $display("FAIL stall_len: got %0d required 10", st); end
    vectors++; if (sb != 0) begin miscompares++; $display("FAIL stall_bus: got %0d bad cycles required 0", sb); end
    vectors++; if (rise_t.size() != 24) begin miscompares++; $display("FAIL stall_rises: got %0d required 24", rise_t.size()); end
    vectors++; if (rxq.size() != 3) begin miscompares++; $display("FAIL stall_rx_count: got %0d required 3", rxq.size()); end
    for (int k = 0; k < rxq.size() && k < 3; k++) begin
      vectors++; if (rxq[k] !== txq[k]) begin miscompares++; $display("FAIL stall_rx[%0d]: got %h required %h", k, rxq[k], txq[k]); end
    end
  endtask

  task automatic test_mid_start();
    int st, sb;
    int bad = 0;
    loopback = 1'b0; cur_msb = 1'b0;
    txq = '{8'($urandom), 8'($urandom)};
    xfer(3'd2, -1, 0, 15, st, sb);
    for (int j = 0; j < rise_nss.size(); j++) if (rise_nss[j] !== 3'd2) bad++;
    vectors++; if (bad != 0 || rise_nss.size() != 16) begin miscompares++; $display("FAIL ms_nss: got %0d wrong of %0d rises required 0 of 16", bad, rise_nss.size()); end
    vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL ms_done: got %0d required 1", done_cnt); end
    for (int k = 0; k < rxq.size() && k < 2; k++) begin
      vectors++; if (rxq[k] !== exp_rx(k)) begin miscompares++; $display("FAIL ms_rx[%0d]: got %h required %h", k, rxq[k], exp_rx(k)); end
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    loopback = 1'b1; cur_msb = 1'b0;
    clear_mon();
    @(negedge clk); start = 1'b1; dev_sel = 3'd3; num_bytes = 8'd1; tx_valid = 1'b1; tx_data = 8'($urandom);
    @(negedge clk); start = 1'b0;
    while (rise_t.size() < 4 && cyc < 200) begin @(negedge clk); cyc++; end
    vectors++; if (rise_t.size() < 4) begin miscompares++; $display("FAIL rm_reach_bit3: got %0d rises required 4 within 200 cycles", rise_t.size()); end
    tx_valid = 1'b0;
    #2 nreset = 1'b0;
    #1;
    vectors++; if (cop_nss !== IDLE) begin miscompares++; $display("FAIL rm_nss: got %h required %h", cop_nss, IDLE); end
    vectors++; if ({cop_sck, busy} !== 2'b00) begin miscompares++; $display("FAIL rm_sck_busy: got %b required 00", {cop_sck, busy}); end
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (20) @(negedge clk);
    vectors++; if (done_cnt != 0 || rxq.size() != 0) begin miscompares++; $display("FAIL rm_no_pulse: done=%0d rx=%0d required 0 0", done_cnt, rxq.size()); end
    vectors++; if (rise_t.size() != 4) begin miscompares++; $display("FAIL rm_rises: got %0d required 4", rise_t.size()); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int st, sb, n, sidx, mbad;
      logic [DSW-1:0] dev;
      n = $urandom_range(1, 4);
      dev = DSW'($urandom_range(0, 6));
      loopback = 1'($urandom_range(0, 1));
`ifdef COP_SPI_MSB_FIRST_EN
      cur_msb = 1'($urandom_range(0, 1));
`else
      cur_msb = 1'b0;
`endif
      txq.delete();
      for (int k = 0; k < n; k++) txq.push_back(8'($urandom));
      sidx = (n > 1) ? int'($urandom_range(1, n - 1)) : -1;
      xfer(dev, sidx, int'($urandom_range(0, 5)), -1, st, sb);
      mbad = 0;
      for (int j = 0; j < rise_mosi.size() && j < 8*n; j++)
        if (rise_mosi[j] !== exp_bit(txq[j/8], j % 8) || rise_nss[j] !== dev) mbad++;
      vectors++; if (rise_mosi.size() != 8*n) begin miscompares++; $display("FAIL rnd%0d_rises: got %0d required %0d", t, rise_mosi.size(), 8*n); end
      vectors++; if (mbad != 0) begin miscompares++; $display("FAIL rnd%0d_mosi: got %0d bad bits required 0", t, mbad); end
      vectors++; if (rxq.size() != n) begin miscompares++; $display("FAIL rnd%0d_rx_count: got %0d required %0d", t, rxq.size(), n); end
      for (int k = 0; k < rxq.size() && k < n; k++) begin
        vectors++; if (rxq[k] !== exp_rx(k)) begin miscompares++; $display("FAIL rnd%0d_rx[%0d]: got %h required %h", t, k, rxq[k], exp_rx(k)); end
      end
      vectors++; if (sb != 0 || done_cnt != 1) begin miscompares++; $display("FAIL rnd%0d_ctrl: stall_bad=%0d done=%0d required 0 1", t, sb, done_cnt); end
    end
  endtask

`ifdef COP_SPI_MSB_FIRST_EN
  task automatic test_msb_first();
    int st, sb;
    loopback = 1'b1; cur_msb = 1'b1;
    txq = '{8'h01};
    xfer(3'd5, -1, 0, -1, st, sb);
    vectors++; if (rise_mosi.size() != 8) begin miscompares++; $display("FAIL msb_rises: got %0d required 8", rise_mosi.size()); end
    for (int j = 0; j < rise_mosi.size() && j < 8; j++) begin
      vectors++; if (rise_mosi[j] !== exp_bit(8'h01, j)) begin miscompares++; $display("FAIL msb_mosi[%0d]: got %b required %b", j, rise_mosi[j], exp_bit(8'h01, j)); end
    end
    vectors++; if (rxq.size() != 1 || rxq[0] !== 8'h01) begin miscompares++; $display("FAIL msb_rx: got count %0d required one byte 01", rxq.size()); end
    cur_msb = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_loopback_0f();
    test_zero_len();
    test_stall();
    test_mid_start();
    test_reset_mid();
    test_random();
`ifdef COP_SPI_MSB_FIRST_EN
    test_msb_first();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
